matmul_result_tx: RTL and testbench



---
 rtl/matmul_pkg.sv | 11 +
 rtl/matmul_result_tx_if.sv | 22 ++
 rtl/mat_fifo.sv | 43 ++++
 rtl/matmul_result_tx.sv | 53 +++++
 tb/tb_matmul_result_tx.sv | 117 +++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared element width, element count and result-matrix type for the 2x2 multiplier
package matmul_pkg;
   localparam int ELEM_W = 8;
   localparam int N_ELEM = 4;
   typedef struct packed {
      logic [ELEM_W-1:0] c00;
      logic [ELEM_W-1:0] c01;
      logic [ELEM_W-1:0] c10;
      logic [ELEM_W-1:0] c11;
   } mat_t;
endpackage

// File: rtl/matmul_result_tx_if.sv
// matmul_result_tx_if: matrix-in and byte-out handshake bundle of the result drain
interface matmul_result_tx_if #(parameter int ELEM_W = 8);
   logic              c_valid;
   logic              c_ready;
   logic [ELEM_W-1:0] c00;
   logic [ELEM_W-1:0] c01;
   logic [ELEM_W-1:0] c10;
   logic [ELEM_W-1:0] c11;
   logic [ELEM_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_last;
   logic              tx_ready;
   logic              busy;
   modport master (
      output c_valid, c00, c01, c10, c11, tx_ready,
      input  c_ready, tx_data, tx_valid, tx_last, busy
   );
   modport slave (
      input  c_valid, c00, c01, c10, c11, tx_ready,
      output c_ready, tx_data, tx_valid, tx_last, busy
   );
endinterface

// File: rtl/mat_fifo.sv
// mat_fifo: DEPTH-entry FIFO of whole result matrices with occupancy count
module mat_fifo
   import matmul_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  mat_t          din,
   input  logic          pop,
   output mat_t          dout,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   mat_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign dout = mem[rd_ptr];

   // storage is not reset; stale contents are masked by count
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // pointers wrap modulo DEPTH; push and pop together leave count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/matmul_result_tx.sv
// matmul_result_tx: buffers 2x2 result matrices and streams them out row-major as bytes
module matmul_result_tx
   import matmul_pkg::*;
#(
   parameter int ELEM_W = 8,
   parameter int DEPTH  = 2
) (
   input logic               clk,
   input logic               rst_n,
   matmul_result_tx_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(N_ELEM);
   logic [CW-1:0]     count;
   logic [IW-1:0]     elem_idx, elem_nxt;
   logic [ELEM_W-1:0] sel;
   mat_t              head, din;
   logic              push, pop, fire;

   assign din = {bus.c00, bus.c01, bus.c10, bus.c11};

   mat_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   // handshake glue, byte select and next element index; c_ready looks only at registered count
   always_comb begin
      bus.c_ready  = (count < CW'(DEPTH)) && rst_n;
      bus.tx_valid = count != '0;
      bus.busy     = bus.tx_valid;
      bus.tx_last  = bus.tx_valid && (elem_idx == IW'(N_ELEM - 1));
      fire         = bus.tx_valid && bus.tx_ready;
      pop          = fire && bus.tx_last;
      push         = bus.c_valid && bus.c_ready;
      sel          = (elem_idx == 2'd0) ? head.c00 :
                     (elem_idx == 2'd1) ? head.c01 :
                     (elem_idx == 2'd2) ? head.c10 : head.c11;
      bus.tx_data  = bus.tx_valid ? sel : '0;
      elem_nxt     = fire ? elem_idx + 1'b1 : elem_idx;
   end

   // element index wraps from C11 back to C00 on the last-byte handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) elem_idx <= '0;
      else        elem_idx <= elem_nxt;
   end
endmodule

// File: tb/tb_matmul_result_tx.sv
// tb_matmul_result_tx: directed and random checks of the result drain against a queue model
module tb_matmul_result_tx;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;

   matmul_result_tx_if #(.ELEM_W(8)) bus ();
   matmul_result_tx #(.ELEM_W(8), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mats[$];
   int          bi = 0;
   logic        acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive inputs, compare outputs with the model, advance the model
   task automatic cyc(input logic cv, input logic [31:0] m, input logic tr, output logic accepted);
      logic       ev;
      logic [7:0] ed;
      bus.c_valid  = cv;
      {bus.c00, bus.c01, bus.c10, bus.c11} = m;
      bus.tx_ready = tr;
      ev = mats.size() != 0;
      ed = ev ? mats[0][31-8*bi -: 8] : 8'h00;
      chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
      chk("tx_data",  32'(bus.tx_data),  32'(ed));
      chk("tx_last",  32'(bus.tx_last),  32'(ev && bi == 3));
      chk("busy",     32'(bus.busy),     32'(ev));
      chk("c_ready",  32'(bus.c_ready),  32'(mats.size() < 2));
      accepted = cv && mats.size() < 2;
      if (ev && tr) begin
         bi++;
         if (bi == 4) begin
            void'(mats.pop_front());
            bi = 0;
         end
      end
      if (accepted) mats.push_back(m);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.c_valid = 0;
      {bus.c00, bus.c01, bus.c10, bus.c11} = '0;
      bus.tx_ready = 0;
      #2;
      chk("rst_c_ready",  32'(bus.c_ready),  0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("rst_tx_last",  32'(bus.tx_last),  0);
      chk("rst_tx_data",  32'(bus.tx_data),  0);
      chk("rst_busy",     32'(bus.busy),     0);
      #10;
      rst_n = 1;
      #1;
      chk("post_rst_c_ready", 32'(bus.c_ready), 1);
      @(posedge clk);
      #1;
      // single matrix 19,22,43,50
      cyc(1, 32'h13162B32, 1, acc);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, acc);
      // backpressure 1,0,0 pattern
      cyc(1, 32'hA1B2C3D4, 0, acc);
      for (int i = 0; i < 14; i++) cyc(0, 0, (i % 3) == 0, acc);
      // buffer full: third matrix waits for the first C11 handshake
      cyc(1, 32'h01020304, 0, acc);
      cyc(1, 32'h05060708, 0, acc);
      cyc(1, 32'h090A0B0C, 0, acc);
      chk("third_blocked", 32'(acc), 0);
      acc = 0;
      for (int i = 0; i < 20 && !acc; i++) cyc(1, 32'h090A0B0C, 1, acc);
      chk("third_accepted", 32'(acc), 1);
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, acc);
      // push coinciding with the C11 pop at count=1
      cyc(1, 32'h11223344, 1, acc);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, acc);
      cyc(1, 32'h55667788, 1, acc);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, acc);
      // max values pass through unchanged
      cyc(1, 32'hE1E1E1E1, 1, acc);
      cyc(1, 32'hFFFFFFFF, 1, acc);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, acc);
      // random traffic
      for (int i = 0; i < 300; i++) cyc(1'($urandom), $urandom, 1'($urandom), acc);
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, acc);
      // reset after two bytes of a matrix
      cyc(1, 32'hDEADBEEF, 1, acc);
      cyc(0, 0, 1, acc);
      cyc(0, 0, 1, acc);
      rst_n = 0;
      #1;
      chk("mid_rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("mid_rst_tx_data",  32'(bus.tx_data),  0);
      chk("mid_rst_tx_last",  32'(bus.tx_last),  0);
      chk("mid_rst_busy",     32'(bus.busy),     0);
      chk("mid_rst_c_ready",  32'(bus.c_ready),  0);
      mats.delete();
      bi = 0;
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, acc);
      cyc(1, 32'h0F1E2D3C, 1, acc);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, acc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
